mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port table memory (memory_if-style: enable, wr_en, addr, write_data, read_data) between two requesters: requester 0 is the APB register block's table path, requester 1 is a hardware engine.
- Arbitration is round-robin per access.
- A lock lets the current owner do back-to-back (read-modify-write) accesses without the other requester getting in.
- Out-of-range addresses get an error response and never reach the memory.

Parameters:
- ADDR_W, 5, width of table address.
- DATA_W, 96, width of a table entry.
- DEPTH, 21, number of valid entries; an address >= DEPTH is an error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; sampled with req
- addr0 / addr1  in  ADDR_W  entry address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  keep ownership after this access
- gnt0 / gnt1  out  1  access accepted this cycle
- rvalid0 / rvalid1  out  1  read data / response valid
- rdata0 / rdata1  out  DATA_W  read data
- err0 / err1  out  1  address out of range; qualified by rvalid
- mem_enable  out  1  memory enable
- mem_wr_en  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read enable

Behaviour:
- Reset (asynchronous, rst=1): last_owner = 1 (requester 0 has priority first); owner FSM = FREE.
- Reset values of outputs: gnt*, rvalid*, err* and mem_* all 0; rdata* 0.
- Owner FSM states:
  - FREE: grant follows round-robin.
  - OWN0 / OWN1: only that requester may be granted; the other's req is ignored.
- FSM transitions:
  - FREE -> OWNn on gnt_n with lock_n = 1.
  - OWNn -> FREE on gnt_n with lock_n = 0.
  - OWNn stays OWNn while req_n = 0.
- Grant is combinational in the same cycle as req.
  - In FREE with both requesting: grant the requester other than last_owner.
  - In FREE with one requesting: grant it.
  - At most one gnt per cycle.
  - last_owner updates on every grant.
- On a grant with addr < DEPTH, mem_* are driven combinationally from the granted requester in the same cycle: mem_enable = 1, mem_wr_en = we, mem_addr = addr, mem_wdata = wdata.
- On a grant with addr >= DEPTH: no memory access (mem_enable = 0).
- Response pipeline (one register stage holds id, we and err):
  - Cycle after a granted read: rvalid_n = 1, rdata_n = mem_rdata, err_n = 0.
  - Cycle after a granted write: rvalid_n = 1 as write acknowledge, rdata_n = 0.
  - Cycle after an error access: rvalid_n = 1, err_n = 1, rdata_n = 0.
- Throughput: one access per cycle sustained; latency grant -> rvalid = 1 cycle.
- rdata_n holds its last value when rvalid_n = 0; rdata is only meaningful when qualified by rvalid.
- Boundaries:
  - addr = DEPTH-1 is valid.
  - addr = DEPTH is an error.
  - addr = 2^ADDR_W - 1 is an error.
- A request with lock_n = 1 that returns err still enters or keeps OWNn; ownership is released only by a lock_n = 0 grant.
- Reset asserted mid-operation: the in-flight response is dropped (no rvalid) and the FSM returns to FREE.
- A requester changing addr/we/wdata while req is held and not granted is legal; the values at the grant cycle are used.

Optional Feature:
- Macro MEM_PORT_ARB_PERF_CNT_EN.
- When defined, adds three outputs, all reset to 0 and saturating at all-ones:
  - gnt_cnt0 (32 bits): +1 per gnt0.
  - gnt_cnt1 (32 bits): +1 per gnt1.
  - conflict_cnt (32 bits): +1 per cycle where both req are high, or where a req is blocked by the other's ownership.
- Adds input perf_clr (1 bit): synchronous clear of all counters; clear wins over increment in the same cycle.
- When not defined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Write then read, single requester: req0 write addr 3, wdata 96'hA5 -> gnt0 in the same cycle; mem_wr_en = 1, mem_addr = 3; next cycle rvalid0 = 1, err0 = 0. Then req0 read addr 3 -> next cycle rdata0 = 96'hA5.
- Round-robin: req0 and req1 held high for 4 cycles after reset -> grants alternate 0,1,0,1; one rvalid per cycle to the matching requester.
- Lock: req1 with lock1 = 1 for 3 accesses while req0 is held high -> gnt0 = 0 throughout. After req1 with lock1 = 0, gnt1; the next cycle gnt0 = 1.
- Range check: req0 read addr 20 -> memory read, err0 = 0. req0 read addr 21, then addr 31 -> mem_enable = 0; next cycle rvalid0 = 1, err0 = 1, rdata0 = 0.
- Reset mid-access: assert rst in the cycle after a read grant -> rvalid0 = 0 immediately and all outputs 0. After release, req1 alone -> gnt1 in the same cycle.
- With MEM_PORT_ARB_PERF_CNT_EN: 5 cycles of dual requests -> gnt_cnt0 = 3, gnt_cnt1 = 2, conflict_cnt = 5. perf_clr pulse -> all counters 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester channels and the single-port table memory bus
// used by mem_port_arbiter.
//   Requester n (n = 0,1): req, we, addr, wdata, lock  -> arbiter
//                          gnt, rvalid, rdata, err     <- arbiter
//   Memory side:  mem_enable, mem_wr_en, mem_addr, mem_wdata <- arbiter
//                 mem_rdata (valid one cycle after a read)    -> arbiter
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 96
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              lock0;
    logic              lock1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              err0;
    logic              err1;
    logic              mem_enable;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_enable, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_enable, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port table memory between requester 0 (APB table path)
// and requester 1 (hardware engine). Round-robin per access, with a lock that
// lets the current owner perform back-to-back accesses (read-modify-write)
// without interference. Out-of-range addresses (>= DEPTH) are answered with an
// error response and never reach the memory.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   bus (slave)  - requester channels and memory bus, see mem_port_arbiter_if
//   perf_clr     - (optional) synchronous clear of the performance counters
//   gnt_cnt0/1   - (optional) saturating grant counters per requester
//   conflict_cnt - (optional) saturating count of contended/blocked cycles
//
// Optional feature: define MEM_PORT_ARB_PERF_CNT_EN to add the performance
// counters and perf_clr.
//
// Timing: grant and memory command are combinational in the request cycle;
// the response (rvalid/rdata/err) appears exactly one cycle later.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 96,
    parameter int DEPTH  = 21
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MEM_PORT_ARB_PERF_CNT_EN
    input  logic                  perf_clr,
    output logic [31:0]           gnt_cnt0,
    output logic [31:0]           gnt_cnt1,
    output logic [31:0]           conflict_cnt,
`endif
    mem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= DEPTH_C);
    endfunction

    own_state_t        state_q, state_d;
    logic              last_owner_q, last_owner_d;

    logic              gnt0_p0, gnt1_p0, gnt_any_p0;
    logic              id_p0, we_p0, err_p0, mem_en_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic              vld_p1, id_p1, we_p1, err_p1;
    logic              rvalid0_p1, rvalid1_p1;
    logic [DATA_W-1:0] resp_data_p1;
    logic [DATA_W-1:0] rdata_hold0_q, rdata_hold1_q;

    // ---- stage p0: arbitration and memory command (combinational) ----
    // Grants are suppressed while reset is asserted so every output reads 0.
    always_comb begin
        gnt0_p0      = 1'b0;
        gnt1_p0      = 1'b0;
        state_d      = state_q;
        last_owner_d = last_owner_q;
        if (!rst) begin
            case (state_q)
                FREE: begin
                    if (bus.req0 && bus.req1) begin
                        // Whoever did not go last wins the tie.
                        gnt0_p0 = last_owner_q;
                        gnt1_p0 = !last_owner_q;
                    end else begin
                        gnt0_p0 = bus.req0;
                        gnt1_p0 = bus.req1;
                    end
                end
                OWN0:    gnt0_p0 = bus.req0;
                OWN1:    gnt1_p0 = bus.req1;
                default: state_d = FREE;
            endcase
        end
        if (gnt0_p0) begin
            state_d      = bus.lock0 ? OWN0 : FREE;
            last_owner_d = 1'b0;
        end else if (gnt1_p0) begin
            state_d      = bus.lock1 ? OWN1 : FREE;
            last_owner_d = 1'b1;
        end
    end

    assign gnt_any_p0 = gnt0_p0 | gnt1_p0;
    assign id_p0      = gnt1_p0;
    assign we_p0      = gnt1_p0 ? bus.we1    : bus.we0;
    assign addr_p0    = gnt1_p0 ? bus.addr1  : bus.addr0;
    assign wdata_p0   = gnt1_p0 ? bus.wdata1 : bus.wdata0;
    assign err_p0     = addr_err(addr_p0);
    assign mem_en_p0  = gnt_any_p0 & ~err_p0;

    assign bus.gnt0       = gnt0_p0;
    assign bus.gnt1       = gnt1_p0;
    assign bus.mem_enable = mem_en_p0;
    assign bus.mem_wr_en  = mem_en_p0 & we_p0;
    assign bus.mem_addr   = mem_en_p0 ? addr_p0  : '0;
    assign bus.mem_wdata  = mem_en_p0 ? wdata_p0 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FREE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // ---- stage p1: response (one register stage: id, we, err) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            id_p1  <= 1'b0;
            we_p1  <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= gnt_any_p0;
            id_p1  <= id_p0;
            we_p1  <= we_p0;
            err_p1 <= err_p0;
        end
    end

    // Memory read data arrives in this cycle, so it is forwarded directly;
    // write acks and errors carry zero data.
    assign resp_data_p1 = (vld_p1 && !we_p1 && !err_p1) ? bus.mem_rdata : '0;
    assign rvalid0_p1   = vld_p1 & ~id_p1;
    assign rvalid1_p1   = vld_p1 &  id_p1;

    // rdata keeps the last response between valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_hold0_q <= '0;
            rdata_hold1_q <= '0;
        end else begin
            if (rvalid0_p1) rdata_hold0_q <= resp_data_p1;
            if (rvalid1_p1) rdata_hold1_q <= resp_data_p1;
        end
    end

    assign bus.rvalid0 = rvalid0_p1;
    assign bus.rvalid1 = rvalid1_p1;
    assign bus.err0    = rvalid0_p1 & err_p1;
    assign bus.err1    = rvalid1_p1 & err_p1;
    assign bus.rdata0  = rvalid0_p1 ? resp_data_p1 : rdata_hold0_q;
    assign bus.rdata1  = rvalid1_p1 ? resp_data_p1 : rdata_hold1_q;

`ifdef MEM_PORT_ARB_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic conflict_p0;

    // Contention: both asking, or one asking while the other holds the lock.
    assign conflict_p0 = (bus.req0 && bus.req1) ||
                         (state_q == OWN0 && bus.req1) ||
                         (state_q == OWN1 && bus.req0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
            conflict_cnt <= '0;
        end else if (perf_clr) begin
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt0_p0)     gnt_cnt0     <= sat_inc(gnt_cnt0);
            if (gnt1_p0)     gnt_cnt1     <= sat_inc(gnt_cnt1);
            if (conflict_p0) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 96;
    localparam int DEPTH  = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_PORT_ARB_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef MEM_PORT_ARB_PERF_CNT_EN
        .perf_clr     (perf_clr),
        .gnt_cnt0     (gnt_cnt0),
        .gnt_cnt1     (gnt_cnt1),
        .conflict_cnt (conflict_cnt),
`endif
        .bus          (bus)
    );

    // Memory attached to the DUT: one-cycle read latency.
    logic [DATA_W-1:0] dut_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.mem_enable) begin
            if (bus.mem_wr_en) dut_mem[bus.mem_addr] <= bus.mem_wdata;
            else               bus.mem_rdata <= dut_mem[bus.mem_addr];
        end
    end

    typedef struct {
        int                cyc;
        bit                rst;
        bit                g0, g1, men, mwe;
        logic [ADDR_W-1:0] maddr;
        logic [DATA_W-1:0] mwdata;
        bit   [31:0]       gc0, gc1, cc;
    } exp_t;

    typedef struct {
        int                due;
        int                id;
        bit                err;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    exp_t  exp_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state (abstract: owner -1 = nobody, 0 or 1).
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int                owner   = -1;
    int                last    = 1;
    int                cur_cyc = 0;
    int                granted = -1;
    bit   [31:0]       m_gc0 = 0, m_gc1 = 0, m_cc = 0;

    function automatic bit [31:0] sat(input bit [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s @cyc%0d: got %0h expected %0h", name, cur_cyc, act, want);
        end
    endtask

    task automatic set_req(input int n, input bit r, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input bit lk);
        if (n == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.lock0 = lk;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.lock1 = lk;
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Evaluate the model on the inputs of this cycle, queue expectations,
    // then advance to just after the next rising edge.
    task automatic do_cycle();
        exp_t              e;
        resp_t             r;
        int                w;
        bit                c0, c1, conflict, we, lk;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        e = '{default: 0};
        e.cyc = cur_cyc;
        e.rst = rst;
        e.gc0 = m_gc0; e.gc1 = m_gc1; e.cc = m_cc;
        w = -1;
        if (rst) begin
            resp_q.delete();
            owner = -1; last = 1;
            m_gc0 = 0; m_gc1 = 0; m_cc = 0;
            e.gc0 = 0; e.gc1 = 0; e.cc = 0;
        end else begin
            c0 = bus.req0 && (owner != 1);
            c1 = bus.req1 && (owner != 0);
            conflict = (bus.req0 && bus.req1) || (owner == 0 && bus.req1) || (owner == 1 && bus.req0);
            if (c0 && c1)  w = (last == 0) ? 1 : 0;
            else if (c0)   w = 0;
            else if (c1)   w = 1;
            if (w >= 0) begin
                a  = (w == 1) ? bus.addr1  : bus.addr0;
                we = (w == 1) ? bus.we1    : bus.we0;
                wd = (w == 1) ? bus.wdata1 : bus.wdata0;
                lk = (w == 1) ? bus.lock1  : bus.lock0;
                e.g0 = (w == 0);
                e.g1 = (w == 1);
                r.due = cur_cyc + 1; r.id = w; r.err = (int'(a) >= DEPTH); r.rdata = '0;
                if (!r.err) begin
                    e.men = 1; e.mwe = we; e.maddr = a; e.mwdata = wd;
                    if (we) ref_mem[a] = wd;
                    else    r.rdata = ref_mem[a];
                end
                resp_q.push_back(r);
                last  = w;
                owner = lk ? w : -1;
            end
`ifdef MEM_PORT_ARB_PERF_CNT_EN
            if (perf_clr) begin
                m_gc0 = 0; m_gc1 = 0; m_cc = 0;
            end else begin
                if (w == 0)   m_gc0 = sat(m_gc0);
                if (w == 1)   m_gc1 = sat(m_gc1);
                if (conflict) m_cc  = sat(m_cc);
            end
`else
            if (conflict) m_cc = sat(m_cc);
`endif
        end
        exp_q.push_back(e);
        granted = w;
        @(posedge clk);
        #1;
        cur_cyc++;
    endtask

    // Request once and hold until the model grants it (bounded).
    task automatic req_once(input int n, input bit we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input bit lk);
        bit got = 0;
        set_req(n, 1'b1, we, a, wd, lk);
        for (int k = 0; k < 32; k++) begin
            do_cycle();
            if (granted == n) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout req%0d: got none expected grant within 32 cycles", n);
        end
        set_req(n, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: compares DUT outputs against queued expectations each cycle.
    exp_t  m_e;
    bit    exp_v;
    logic  act_v, act_err;
    logic [DATA_W-1:0] act_rd;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            chk("grant", {bus.gnt0, bus.gnt1}, {m_e.g0, m_e.g1});
            chk("mem_enable", {bus.mem_enable, bus.mem_wr_en & bus.mem_enable}, {m_e.men, m_e.mwe});
            if (m_e.men) begin
                chk("mem_addr", bus.mem_addr, m_e.maddr);
                chk("mem_wdata", bus.mem_wdata, m_e.mwe ? m_e.mwdata : bus.mem_wdata);
            end
            for (int n = 0; n < 2; n++) begin
                exp_v   = (resp_q.size() > 0) && (resp_q[0].due == m_e.cyc) && (resp_q[0].id == n);
                act_v   = (n == 0) ? bus.rvalid0 : bus.rvalid1;
                act_err = (n == 0) ? bus.err0    : bus.err1;
                act_rd  = (n == 0) ? bus.rdata0  : bus.rdata1;
                chk($sformatf("rvalid%0d", n), act_v, exp_v);
                if (exp_v && act_v) begin
                    chk($sformatf("err%0d", n), act_err, resp_q[0].err);
                    chk($sformatf("rdata%0d", n), act_rd, resp_q[0].rdata);
                end
            end
            while (resp_q.size() > 0 && resp_q[0].due <= m_e.cyc) void'(resp_q.pop_front());
            if (m_e.rst) begin
                chk("reset_outputs", {bus.rdata0, bus.err0, bus.err1}, '0);
                chk("reset_rdata1", bus.rdata1, '0);
            end
`ifdef MEM_PORT_ARB_PERF_CNT_EN
            chk("gnt_cnt0", gnt_cnt0, m_e.gc0);
            chk("gnt_cnt1", gnt_cnt1, m_e.gc1);
            chk("conflict_cnt", conflict_cnt, m_e.cc);
`endif
        end
    end

    bit pend [2];

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
`ifdef MEM_PORT_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_cycle();
        do_cycle();
        rst = 1'b0;

        // Fill the table so every later read has defined contents.
        for (int i = 0; i < DEPTH; i++) req_once(0, 1'b1, ADDR_W'(i), rnd_data(), 1'b0);

        // Write then read, single requester.
        req_once(0, 1'b1, 5'd3, 96'hA5, 1'b0);
        req_once(0, 1'b0, 5'd3, '0, 1'b0);
        do_cycle();

        // Round-robin straight after reset.
        rst = 1'b1; do_cycle(); rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 5'd1, '0, 1'b0);
        set_req(1, 1'b1, 1'b0, 5'd2, '0, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle();
        set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
        do_cycle();

        // Lock: requester 1 keeps the port for three locked accesses.
        set_req(1, 1'b1, 1'b1, 5'd4, rnd_data(), 1'b1);
        do_cycle();
        set_req(0, 1'b1, 1'b0, 5'd4, '0, 1'b0);
        set_req(1, 1'b1, 1'b0, 5'd4, '0, 1'b1);
        do_cycle();
        set_req(1, 1'b1, 1'b1, 5'd4, rnd_data(), 1'b1);
        do_cycle();
        set_req(1, 1'b1, 1'b0, 5'd4, '0, 1'b0);
        do_cycle();
        set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
        do_cycle();
        set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
        do_cycle();

        // Range boundaries, including a locked error access.
        req_once(0, 1'b0, 5'd20, '0, 1'b0);
        req_once(0, 1'b0, 5'd21, '0, 1'b0);
        req_once(0, 1'b0, 5'd31, '0, 1'b1);
        set_req(1, 1'b1, 1'b0, 5'd0, '0, 1'b0);
        do_cycle();
        req_once(0, 1'b1, 5'd31, rnd_data(), 1'b0);
        for (int i = 0; i < 3; i++) do_cycle();
        set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);

        // Reset arriving while a read response is in flight.
        req_once(0, 1'b0, 5'd5, '0, 1'b0);
        rst = 1'b1; do_cycle(); rst = 1'b0;
        req_once(1, 1'b0, 5'd7, '0, 1'b0);
        do_cycle();

        // Five cycles of dual requests from reset, then a counter clear.
        rst = 1'b1; do_cycle(); rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 5'd8, '0, 1'b0);
        set_req(1, 1'b1, 1'b0, 5'd9, '0, 1'b0);
        for (int i = 0; i < 5; i++) do_cycle();
        set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
        do_cycle();
`ifdef MEM_PORT_ARB_PERF_CNT_EN
        perf_clr = 1'b1;
        set_req(0, 1'b1, 1'b0, 5'd1, '0, 1'b0);
        do_cycle();
        perf_clr = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
`endif
        do_cycle();

        // Randomized traffic.
        pend[0] = 0; pend[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 9) < 6) begin
                    set_req(n, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)),
                            rnd_data(), ($urandom_range(0, 3) == 0));
                    pend[n] = 1;
                end else if (pend[n] && $urandom_range(0, 9) == 0) begin
                    if (n == 0) bus.addr0 = ADDR_W'($urandom_range(0, 31));
                    else        bus.addr1 = ADDR_W'($urandom_range(0, 31));
                end
            end
`ifdef MEM_PORT_ARB_PERF_CNT_EN
            perf_clr = ($urandom_range(0, 199) == 0);
`endif
            rst = ($urandom_range(0, 499) == 0);
            do_cycle();
            if (granted >= 0) begin
                pend[granted] = 0;
                set_req(granted, 1'b0, 1'b0, '0, '0, 1'b0);
            end
        end
        rst = 1'b0;
`ifdef MEM_PORT_ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
